decode_regfile: RTL and testbench

Instruction-decode stage feeding the ID/EX pipeline buffer of the 16-bit datapath. Holds the 16×16-bit register file, decodes the instruction word into the 16-bit control word, and drives the buffer's data and control inputs. Accepts writeback, including the dedicated R15 high/remainder write from mul/div. Detects load-use hazards, stalls fetch and injects a bubble.

---
 rtl/decode_regfile_pkg.sv | 30 +++
 rtl/decode_regfile_if.sv | 23 ++
 rtl/decode_regfile_regfile16.sv | 47 ++++
 rtl/decode_regfile.sv | 90 +++++++++
 tb/tb_decode_regfile.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_regfile_pkg.sv
// Shared datapath definitions for the decode stage: word width, opcodes,
// mul/div func codes and bit positions inside the 16-bit control word.
package decode_regfile_pkg;

   localparam int WORD_W = 16;
   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [3:0] {
      OP_RTYPE = 4'b0000,
      OP_BEQ   = 4'b0100,
      OP_LW    = 4'b1000,
      OP_SW    = 4'b1011,
      OP_ADDI  = 4'b1100
   } opcode_e;

   localparam logic [3:0] FUNC_MUL = 4'b0001;
   localparam logic [3:0] FUNC_DIV = 4'b0010;
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0010;

   localparam int CB_REGWRITE = 0;
   localparam int CB_MEMREAD  = 1;
   localparam int CB_MEMWRITE = 2;
   localparam int CB_ALUSRC   = 3;
   localparam int CB_ALUOP_LO = 4;
   localparam int CB_BRANCH   = 8;
   localparam int CB_WRITE15  = 9;
   localparam int CB_DEST_LO  = 12;

endpackage

// File: rtl/decode_regfile_if.sv
// Decode-stage bus: IF/ID instruction in, writeback in, ID/EX operands,
// control word and stall out.
interface decode_regfile_if;
   import decode_regfile_pkg::*;

   word_t      ins;
   logic       val;
   logic       we;
   logic [3:0] wa;
   word_t      wd;
   logic       we15;
   word_t      wd15;
   word_t      od1;
   word_t      od2;
   word_t      od15;
   word_t      oc;
   logic       stl;

   modport master (output ins, val, we, wa, wd, we15, wd15,
                   input  od1, od2, od15, oc, stl);
   modport slave  (input  ins, val, we, wa, wd, we15, wd15,
                   output od1, od2, od15, oc, stl);
endinterface

// File: rtl/decode_regfile_regfile16.sv
// 16x16 register file: two read ports, dedicated R15 read port, one write
// port plus the mul/div R15 port (which wins). Same-cycle forwarding when
// WB_BYPASS_EN is defined.
module regfile16
   import decode_regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] ra1,
   input  logic [3:0] ra2,
   input  logic       we,
   input  logic [3:0] wa,
   input  word_t      wd,
   input  logic       we15,
   input  word_t      wd15,
   output word_t      rd1,
   output word_t      rd2,
   output word_t      rd15
);

   word_t regs [16];

   // The general port yields to the R15 port when both target R15.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) regs[i] <= '0;
      end else begin
         if (we && !(we15 && wa == 4'd15)) regs[wa] <= wd;
         if (we15) regs[15] <= wd15;
      end
   end

   function automatic word_t read_port(input logic [3:0] a);
`ifdef WB_BYPASS_EN
      if (we15 && a == 4'd15) return wd15;
      if (we && wa == a) return wd;
`endif
      return regs[a];
   endfunction

   always_comb begin
      rd1  = read_port(ra1);
      rd2  = read_port(ra2);
      rd15 = read_port(4'd15);
   end

endmodule

// File: rtl/decode_regfile.sv
// Instruction decode stage: control word decode, register reads and
// load-use stall. Optional macro WB_BYPASS_EN forwards same-cycle writeback.
module decode_regfile
   import decode_regfile_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   decode_regfile_if.slave  bus
);

   logic [3:0] op, rs1, rs2, fimm;
   logic [3:0] prev_rd;
   logic       prev_mr;
   logic       known_op;
   logic       alusrc;
   logic       hazard;
   word_t      ctrl;
   word_t      rd2;

   assign op   = bus.ins[15:12];
   assign rs1  = bus.ins[11:8];
   assign rs2  = bus.ins[7:4];
   assign fimm = bus.ins[3:0];

   always_comb begin
      ctrl     = '0;
      known_op = 1'b1;
      case (op)
         OP_RTYPE: begin
            ctrl[CB_REGWRITE]          = 1'b1;
            ctrl[CB_ALUOP_LO +: 4]     = fimm;
            ctrl[CB_WRITE15]           = (fimm == FUNC_MUL) || (fimm == FUNC_DIV);
         end
         OP_LW: begin
            ctrl[CB_REGWRITE] = 1'b1;
            ctrl[CB_MEMREAD]  = 1'b1;
            ctrl[CB_ALUSRC]   = 1'b1;
         end
         OP_SW: begin
            ctrl[CB_MEMWRITE] = 1'b1;
            ctrl[CB_ALUSRC]   = 1'b1;
         end
         OP_BEQ: begin
            ctrl[CB_BRANCH]        = 1'b1;
            ctrl[CB_ALUOP_LO +: 4] = ALU_SUB;
         end
         OP_ADDI: begin
            ctrl[CB_REGWRITE]      = 1'b1;
            ctrl[CB_ALUSRC]        = 1'b1;
            ctrl[CB_ALUOP_LO +: 4] = ALU_ADD;
         end
         default: known_op = 1'b0;
      endcase
      if (known_op) ctrl[CB_DEST_LO +: 4] = rs1;
   end

   // Immediate-operand instructions never depend on the op2 register.
   assign alusrc  = ctrl[CB_ALUSRC];
   assign hazard  = bus.val && prev_mr && ((prev_rd == rs1) || (!alusrc && prev_rd == rs2));
   assign bus.oc  = (bus.val && !hazard) ? ctrl : '0;
   assign bus.stl = hazard;
   assign bus.od2 = alusrc ? {{(WORD_W-4){1'b0}}, fimm} : rd2;

   // History follows what was actually issued, so a bubble clears MemRead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_rd <= '0;
         prev_mr <= 1'b0;
      end else begin
         prev_rd <= bus.oc[CB_DEST_LO +: 4];
         prev_mr <= bus.oc[CB_MEMREAD];
      end
   end

   regfile16 u_regfile (
      .clk  (clk),
      .rst_n(rst_n),
      .ra1  (rs1),
      .ra2  (rs2),
      .we   (bus.we),
      .wa   (bus.wa),
      .wd   (bus.wd),
      .we15 (bus.we15),
      .wd15 (bus.wd15),
      .rd1  (bus.od1),
      .rd2  (rd2),
      .rd15 (bus.od15)
   );

endmodule

// File: tb/tb_decode_regfile.sv
// Self-checking bench for decode_regfile: directed scenarios plus a random
// run against a behavioural model of register file, decode and stall rules.
module tb_decode_regfile;
   import decode_regfile_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   pass_count = 0;
   int   check_count = 0;

`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   always #5 clk = ~clk;

   decode_regfile_if bus ();

   decode_regfile dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   word_t      m_regs [16];
   logic [3:0] m_prev_rd;
   logic       m_prev_mr;

   function automatic word_t exp_ctrl(input word_t ins);
      int opc, dst, fn, c;
      opc = int'(ins[15:12]);
      dst = int'(ins[11:8]);
      fn  = int'(ins[3:0]);
      case (opc)
         0:  c = 1 + fn * 16 + (((fn == 1) || (fn == 2)) ? 512 : 0);
         8:  c = 1 + 2 + 8;
         11: c = 4 + 8;
         4:  c = 256 + 2 * 16;
         12: c = 1 + 8;
         default: return '0;
      endcase
      return word_t'(c + dst * 4096);
   endfunction

   function automatic word_t model_read(input logic [3:0] a);
      if (BYPASS && bus.we15 && a == 4'd15) return bus.wd15;
      if (BYPASS && bus.we && bus.wa == a) return bus.wd;
      return m_regs[a];
   endfunction

   task automatic clear_inputs();
      bus.ins = '0; bus.val = 1'b0; bus.we = 1'b0; bus.wa = '0;
      bus.wd = '0; bus.we15 = 1'b0; bus.wd15 = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      bus.ins = 16'h0120; bus.val = 1'b1;
      @(negedge clk);
      check_count++; if (bus.od1 !== 16'h0) $display("[TB] FAIL reset_od1: got %h expected %h", bus.od1, 16'h0); else pass_count++;
      check_count++; if (bus.od2 !== 16'h0) $display("[TB] FAIL reset_od2: got %h expected %h", bus.od2, 16'h0); else pass_count++;
      check_count++; if (bus.od15 !== 16'h0) $display("[TB] FAIL reset_od15: got %h expected %h", bus.od15, 16'h0); else pass_count++;
      check_count++; if (bus.oc !== 16'h1001) $display("[TB] FAIL reset_oc: got %h expected %h", bus.oc, 16'h1001); else pass_count++;
      check_count++; if (bus.stl !== 1'b0) $display("[TB] FAIL reset_stl: got %b expected %b", bus.stl, 1'b0); else pass_count++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_count++; if (bus.oc !== 16'h1001) $display("[TB] FAIL release_oc: got %h expected %h", bus.oc, 16'h1001); else pass_count++;
      check_count++; if (bus.od1 !== 16'h0) $display("[TB] FAIL release_od1: got %h expected %h", bus.od1, 16'h0); else pass_count++;
   endtask

   task automatic test_writeback();
      word_t same_cycle;
      do_reset();
      same_cycle = BYPASS ? 16'hBEEF : 16'h0000;
      bus.we = 1'b1; bus.wa = 4'd3; bus.wd = 16'hBEEF;
      bus.ins = 16'h0300; bus.val = 1'b1;
      @(negedge clk);
      check_count++; if (bus.od1 !== same_cycle) $display("[TB] FAIL wb_same_cycle: got %h expected %h", bus.od1, same_cycle); else pass_count++;
      @(posedge clk); #1;
      bus.we = 1'b0;
      @(negedge clk);
      check_count++; if (bus.od1 !== 16'hBEEF) $display("[TB] FAIL wb_next_cycle: got %h expected %h", bus.od1, 16'hBEEF); else pass_count++;
      check_count++; if (bus.oc !== 16'h3001) $display("[TB] FAIL wb_oc: got %h expected %h", bus.oc, 16'h3001); else pass_count++;
   endtask

   task automatic test_load_use();
      word_t stall_od1;
      do_reset();
      bus.ins = 16'h8204; bus.val = 1'b1;
      @(negedge clk);
      check_count++; if (bus.oc !== 16'h200B) $display("[TB] FAIL lw_oc: got %h expected %h", bus.oc, 16'h200B); else pass_count++;
      @(posedge clk); #1;
      bus.ins = 16'h0520;
      bus.we = 1'b1; bus.wa = 4'd5; bus.wd = 16'h1234;
      stall_od1 = BYPASS ? 16'h1234 : 16'h0000;
      @(negedge clk);
      check_count++; if (bus.stl !== 1'b1) $display("[TB] FAIL stall_stl: got %b expected %b", bus.stl, 1'b1); else pass_count++;
      check_count++; if (bus.oc !== 16'h0) $display("[TB] FAIL stall_oc: got %h expected %h", bus.oc, 16'h0); else pass_count++;
      check_count++; if (bus.od1 !== stall_od1) $display("[TB] FAIL stall_od1: got %h expected %h", bus.od1, stall_od1); else pass_count++;
      @(posedge clk); #1;
      bus.we = 1'b0;
      @(negedge clk);
      check_count++; if (bus.stl !== 1'b0) $display("[TB] FAIL after_stall_stl: got %b expected %b", bus.stl, 1'b0); else pass_count++;
      check_count++; if (bus.oc !== 16'h5001) $display("[TB] FAIL after_stall_oc: got %h expected %h", bus.oc, 16'h5001); else pass_count++;
      check_count++; if (bus.od1 !== 16'h1234) $display("[TB] FAIL stall_write_commit: got %h expected %h", bus.od1, 16'h1234); else pass_count++;
   endtask

   task automatic test_addi_no_stall();
      do_reset();
      bus.ins = 16'h8204; bus.val = 1'b1;
      @(posedge clk); #1;
      bus.ins = 16'hC527;
      @(negedge clk);
      check_count++; if (bus.stl !== 1'b0) $display("[TB] FAIL addi_stl: got %b expected %b", bus.stl, 1'b0); else pass_count++;
      check_count++; if (bus.od2 !== 16'h0007) $display("[TB] FAIL addi_od2: got %h expected %h", bus.od2, 16'h0007); else pass_count++;
      check_count++; if (bus.oc !== 16'h5009) $display("[TB] FAIL addi_oc: got %h expected %h", bus.oc, 16'h5009); else pass_count++;
   endtask

   task automatic test_r15_priority();
      do_reset();
      bus.we15 = 1'b1; bus.wd15 = 16'h1111;
      bus.we = 1'b1; bus.wa = 4'd15; bus.wd = 16'h2222;
      bus.ins = 16'h0F00; bus.val = 1'b1;
      @(posedge clk); #1;
      bus.we15 = 1'b0; bus.we = 1'b0;
      @(negedge clk);
      check_count++; if (bus.od15 !== 16'h1111) $display("[TB] FAIL r15_od15: got %h expected %h", bus.od15, 16'h1111); else pass_count++;
      check_count++; if (bus.od1 !== 16'h1111) $display("[TB] FAIL r15_od1: got %h expected %h", bus.od1, 16'h1111); else pass_count++;
   endtask

   task automatic test_nop_and_mul();
      do_reset();
      bus.ins = 16'h7123; bus.val = 1'b1;
      @(negedge clk);
      check_count++; if (bus.oc !== 16'h0) $display("[TB] FAIL nop_oc: got %h expected %h", bus.oc, 16'h0); else pass_count++;
      @(posedge clk); #1;
      bus.ins = 16'h8204;
      @(posedge clk); #1;
      bus.ins = 16'h0520; bus.val = 1'b0;
      @(negedge clk);
      check_count++; if (bus.oc !== 16'h0) $display("[TB] FAIL invalid_oc: got %h expected %h", bus.oc, 16'h0); else pass_count++;
      check_count++; if (bus.stl !== 1'b0) $display("[TB] FAIL invalid_stl: got %b expected %b", bus.stl, 1'b0); else pass_count++;
      @(posedge clk); #1;
      bus.ins = 16'h0121; bus.val = 1'b1;
      @(negedge clk);
      check_count++; if (bus.oc !== 16'h1211) $display("[TB] FAIL mul_oc: got %h expected %h", bus.oc, 16'h1211); else pass_count++;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      bus.ins = 16'h8204; bus.val = 1'b1;
      @(posedge clk); #1;
      bus.ins = 16'h0520;
      @(negedge clk);
      check_count++; if (bus.stl !== 1'b1) $display("[TB] FAIL midstall_pre: got %b expected %b", bus.stl, 1'b1); else pass_count++;
      rst_n = 1'b0;
      #1;
      check_count++; if (bus.stl !== 1'b0) $display("[TB] FAIL midstall_clear: got %b expected %b", bus.stl, 1'b0); else pass_count++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_count++; if (bus.oc !== 16'h5001) $display("[TB] FAIL midstall_fresh_oc: got %h expected %h", bus.oc, 16'h5001); else pass_count++;
   endtask

   task automatic test_random();
      logic [3:0] opc, f1, f2, f3;
      word_t      ctrl, e_oc, e_od1, e_od2, e_od15;
      logic       e_hz, alusrc;
      do_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_prev_rd = '0;
      m_prev_mr = 1'b0;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 6))
            0: opc = 4'h0;
            1, 2: opc = 4'h8;
            3: opc = 4'hB;
            4: opc = 4'h4;
            5: opc = 4'hC;
            default: opc = 4'($urandom_range(0, 15));
         endcase
         f1 = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
         f2 = 4'($urandom_range(0, 3));
         f3 = 4'($urandom_range(0, 15));
         bus.ins  = {opc, f1, f2, f3};
         bus.val  = ($urandom_range(0, 9) != 0);
         bus.we   = 1'($urandom_range(0, 1));
         bus.wa   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
         bus.wd   = 16'($urandom);
         bus.we15 = ($urandom_range(0, 4) == 0);
         bus.wd15 = 16'($urandom);

         ctrl   = exp_ctrl(bus.ins);
         alusrc = ctrl[3];
         e_hz   = bus.val && m_prev_mr && (m_prev_rd == f1 || (!alusrc && m_prev_rd == f2));
         e_oc   = (bus.val && !e_hz) ? ctrl : '0;
         e_od1  = model_read(f1);
         e_od2  = alusrc ? word_t'(f3) : model_read(f2);
         e_od15 = model_read(4'd15);

         @(negedge clk);
         check_count++; if (bus.oc !== e_oc) $display("[TB] FAIL rand_oc[%0d]: got %h expected %h", n, bus.oc, e_oc); else pass_count++;
         check_count++; if (bus.stl !== e_hz) $display("[TB] FAIL rand_stl[%0d]: got %b expected %b", n, bus.stl, e_hz); else pass_count++;
         check_count++; if (bus.od1 !== e_od1) $display("[TB] FAIL rand_od1[%0d]: got %h expected %h", n, bus.od1, e_od1); else pass_count++;
         check_count++; if (bus.od2 !== e_od2) $display("[TB] FAIL rand_od2[%0d]: got %h expected %h", n, bus.od2, e_od2); else pass_count++;
         check_count++; if (bus.od15 !== e_od15) $display("[TB] FAIL rand_od15[%0d]: got %h expected %h", n, bus.od15, e_od15); else pass_count++;

         if (bus.we) m_regs[bus.wa] = bus.wd;
         if (bus.we15) m_regs[15] = bus.wd15;
         m_prev_rd = e_oc[15:12];
         m_prev_mr = e_oc[1];
         @(posedge clk); #1;
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_writeback();
      test_load_use();
      test_addi_no_stall();
      test_r15_priority();
      test_nop_and_mul();
      test_reset_mid_stall();
      test_random();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
